// File: rtl/button_conditioner.sv
// Gamepad front end: synchronises and debounces eight raw button lines, auto-repeats
// left/right/down, and issues one-hot single-cycle press pulses in fixed priority order.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn_raw,
  output logic [7:0] btn_level,
  output logic       left,
  output logic       right,
  output logic       down,
  output logic       up,
  output logic       select,
  output logic       start,
  output logic       a,
  output logic       b
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int N_REP   = 3;

  localparam logic [7:0]       RELEASED    = {8{ACTIVE_LOW}};
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [7:0]       sync1, sync2, level_sync, level_next;
  logic [DB_W-1:0]  db_cnt [8];
  logic [REP_W-1:0] rep_cnt [N_REP];
  logic [N_REP-1:0] repeating, rep_fire;
  logic [7:0]       pending, grant, events, pulse;

  // Synchroniser resets to the released level so a held button is never seen as pressed early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign level_sync = ACTIVE_LOW ? ~sync2 : sync2;

  always_comb begin
    level_next = btn_level;
    for (int i = 0; i < 8; i++) begin
      if (level_sync[i] != btn_level[i] && db_cnt[i] == DB_LAST)
        level_next[i] = ~btn_level[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      btn_level <= level_next;
      for (int i = 0; i < 8; i++) begin
        if (level_sync[i] == btn_level[i] || db_cnt[i] == DB_LAST)
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  // Counter restarts at each repeat; 'repeating' selects the initial delay or the period.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_REP; i++) begin
      rep_fire[i] = btn_level[i] &&
                    (repeating[i] ? (rep_cnt[i] == PERIOD_LAST) : (rep_cnt[i] == DELAY_LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeating <= '0;
      for (int i = 0; i < N_REP; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REP; i++) begin
        if (!btn_level[i]) begin
          rep_cnt[i]   <= '0;
          repeating[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i]   <= '0;
          repeating[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest set pending bit wins; a new event in the grant cycle re-sets the bit (set beats clear).
  assign grant  = pending & (~pending + 8'd1);
  assign events = (level_next & ~btn_level) | {5'b0, rep_fire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      pulse   <= '0;
    end else begin
      pending <= (pending & ~grant) | events;
      pulse   <= grant;
    end
  end

  assign {b, a, start, select, up, down, right, left} = pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with spec-derived timing plus
// randomized button traffic compared cycle by cycle against a behavioural model.
module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] btn_raw = 8'h00;
  logic [7:0] raw_n = 8'hFF;
  logic [7:0] btn_level, level_n;
  logic       left, right, down, up, select, start, a, b;
  logic       left_n, right_n, down_n, up_n, select_n, start_n, a_n, b_n;
  logic [7:0] pls, pls_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] lvl_log [0:127];
  logic [7:0] pls_log [0:127];

  assign pls   = {b, a, start, select, up, down, right, left};
  assign pls_n = {b_n, a_n, start_n, select_n, up_n, down_n, right_n, left_n};

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
    .left(left), .right(right), .down(down), .up(up),
    .select(select), .start(start), .a(a), .b(b)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_n), .btn_level(level_n),
    .left(left_n), .right(right_n), .down(down_n), .up(up_n),
    .select(select_n), .start(start_n), .a(a_n), .b(b_n)
  );

  // Behavioural model: raw seen two cycles late, a level flips after DB differing
  // cycles, repeats from hold time arithmetic, lowest pending index issued first.
  logic [7:0] m_s1, m_s2, m_level, m_pend, m_pulse;
  logic [7:0] m_level_n, m_pend_n, m_pulse_n;
  logic [2:0] m_rep;
  int         m_run [8];
  int         m_run_n [8];
  int         m_held [3];
  int         m_held_n [3];
  int         m_first;

  always_comb begin
    m_level_n = m_level;
    m_rep     = '0;
    m_pulse_n = '0;
    m_first   = -1;
    for (int i = 0; i < 8; i++) begin
      m_run_n[i] = (m_s2[i] != m_level[i]) ? m_run[i] + 1 : 0;
      if (m_run_n[i] == DB) begin
        m_level_n[i] = ~m_level[i];
        m_run_n[i]   = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      m_held_n[i] = m_level[i] ? m_held[i] + 1 : 0;
      if (m_level[i] && (m_held_n[i] == DLY ||
          (m_held_n[i] > DLY && (m_held_n[i] - DLY) % PER == 0)))
        m_rep[i] = 1'b1;
    end
    for (int i = 7; i >= 0; i--) begin
      if (m_pend[i]) m_first = i;
    end
    if (m_first >= 0) m_pulse_n[m_first] = 1'b1;
    m_pend_n = (m_pend & ~m_pulse_n) | (m_level_n & ~m_level) | {5'b0, m_rep};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0; m_pend <= '0; m_pulse <= '0;
      for (int i = 0; i < 8; i++) m_run[i] <= 0;
      for (int i = 0; i < 3; i++) m_held[i] <= 0;
    end else begin
      m_s1 <= btn_raw; m_s2 <= m_s1; m_level <= m_level_n; m_pend <= m_pend_n;
      m_pulse <= m_pulse_n;
      for (int i = 0; i < 8; i++) m_run[i] <= m_run_n[i];
      for (int i = 0; i < 3; i++) m_held[i] <= m_held_n[i];
    end
  end

  // Drives val from edge 0, releases it so edge 'hold' samples 0, logs after each edge.
  task automatic run_window(input logic [7:0] val, input int hold, input int total);
    btn_raw = val;
    for (int e = 0; e < total; e++) begin
      @(posedge clk);
      @(negedge clk);
      lvl_log[e] = btn_level;
      pls_log[e] = pls;
      if (e == hold - 1) btn_raw = 8'h00;
    end
  endtask

  task automatic test_reset;
    btn_raw = 8'h00;
    raw_n   = 8'hFF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({btn_level, pls} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_async: level/pulse got %h want 0000", {btn_level, pls});
    end
    n_checks++;
    if ({level_n, pls_n} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_async_n: level/pulse got %h want 0000", {level_n, pls_n});
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({btn_level, pls} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_clocked: level/pulse got %h want 0000", {btn_level, pls});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cnt = 0;
    run_window(8'h01, 13, 26);
    n_checks++;
    if (lvl_log[DB][0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_level_early: got %b want 0", lvl_log[DB][0]);
    end
    n_checks++;
    if (lvl_log[DB+1][0] !== 1'b1) begin
      n_fail++; $display("FAIL basic_level_rise: got %b want 1", lvl_log[DB+1][0]);
    end
    n_checks++;
    if (pls_log[DB+2] !== 8'h01) begin
      n_fail++; $display("FAIL basic_pulse: got %h want 01", pls_log[DB+2]);
    end
    n_checks++;
    if (pls_log[DB+3] !== 8'h00) begin
      n_fail++; $display("FAIL basic_pulse_width: got %h want 00", pls_log[DB+3]);
    end
    for (int e = 0; e < 26; e++) cnt += $countones(pls_log[e]);
    n_checks++;
    if (cnt != 1) begin
      n_fail++; $display("FAIL basic_pulse_count: got %0d want 1", cnt);
    end
    n_checks++;
    if (lvl_log[13+DB][0] !== 1'b1 || lvl_log[13+DB+1][0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: got %b%b want 10", lvl_log[13+DB][0], lvl_log[13+DB+1][0]);
    end
  endtask

  task automatic test_glitch;
    run_window(8'h10, 3, 16);
    for (int e = 0; e < 16; e++) begin
      n_checks++;
      if ({lvl_log[e], pls_log[e]} !== 16'h0000) begin
        n_fail++; $display("FAIL glitch edge %0d: level/pulse got %h want 0000", e, {lvl_log[e], pls_log[e]});
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp;
    run_window(8'hC1, 12, 26);
    n_checks++;
    if (lvl_log[DB+1] !== 8'hC1) begin
      n_fail++; $display("FAIL simul_level: got %h want c1", lvl_log[DB+1]);
    end
    for (int e = 0; e < 26; e++) begin
      exp = (e == DB+2) ? 8'h01 : (e == DB+3) ? 8'h40 : (e == DB+4) ? 8'h80 : 8'h00;
      n_checks++;
      if (pls_log[e] !== exp) begin
        n_fail++; $display("FAIL simul_pulse edge %0d: got %h want %h", e, pls_log[e], exp);
      end
    end
  endtask

  task automatic test_repeat;
    logic [7:0] exp;
    int cnt = 0;
    run_window(8'h02, 56, 76);
    for (int e = 0; e < 76; e++) begin
      exp = (e == DB+2) ? 8'h02 : 8'h00;
      for (int k = 0; k < 5; k++) if (e == DB + 2 + DLY + PER*k) exp = 8'h02;
      n_checks++;
      if (pls_log[e] !== exp) begin
        n_fail++; $display("FAIL repeat_right edge %0d: got %h want %h", e, pls_log[e], exp);
      end
    end
    n_checks++;
    if (lvl_log[56+DB] !== 8'h02 || lvl_log[56+DB+1] !== 8'h00) begin
      n_fail++; $display("FAIL repeat_release: got %h %h want 02 00", lvl_log[56+DB], lvl_log[56+DB+1]);
    end
    run_window(8'h20, 56, 76);
    for (int e = 0; e < 76; e++) cnt += $countones(pls_log[e]);
    n_checks++;
    if (cnt != 1 || pls_log[DB+2] !== 8'h20) begin
      n_fail++; $display("FAIL repeat_start: got %0d pulses, edge6 %h want 1 pulse 20", cnt, pls_log[DB+2]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp;
    run_window(8'h04, 1000, DB + 17);
    n_checks++;
    if (pls_log[DB+2] !== 8'h04 || btn_level !== 8'h04) begin
      n_fail++; $display("FAIL resetmid_pre: pulse %h level %h want 04 04", pls_log[DB+2], btn_level);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({btn_level, pls} !== 16'h0000) begin
      n_fail++; $display("FAIL resetmid_async: got %h want 0000", {btn_level, pls});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(8'h04, 25, 40);
    n_checks++;
    if (lvl_log[DB] !== 8'h00 || lvl_log[DB+1] !== 8'h04) begin
      n_fail++; $display("FAIL resetmid_level: got %h %h want 00 04", lvl_log[DB], lvl_log[DB+1]);
    end
    for (int e = 0; e < 40; e++) begin
      exp = (e == DB+2 || e == DB+2+DLY) ? 8'h04 : 8'h00;
      n_checks++;
      if (pls_log[e] !== exp) begin
        n_fail++; $display("FAIL resetmid_pulse edge %0d: got %h want %h", e, pls_log[e], exp);
      end
    end
  endtask

  task automatic test_polarity;
    logic [7:0] exp;
    raw_n = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({level_n, pls_n} !== 16'h0000) begin
        n_fail++; $display("FAIL polarity_idle cycle %0d: got %h want 0000", c, {level_n, pls_n});
      end
    end
    raw_n = 8'hF7;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (e == DB+2) ? 8'h08 : 8'h00;
      n_checks++;
      if (pls_n !== exp) begin
        n_fail++; $display("FAIL polarity_up edge %0d: got %h want %h", e, pls_n, exp);
      end
      if (e == DB+1) begin
        n_checks++;
        if (level_n !== 8'h08) begin
          n_fail++; $display("FAIL polarity_level: got %h want 08", level_n);
        end
      end
    end
    raw_n = 8'hFF;
  endtask

  task automatic test_random;
    for (int s = 0; s <= 24; s++) begin
      logic [7:0] v;
      int         len;
      v   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      len = $urandom_range(1, 45);
      if ($urandom_range(0, 2) == 0) v = 8'($urandom_range(1, 7));
      if (s == 24) begin
        v   = 8'h00;
        len = 40;
      end
      btn_raw = v;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (btn_level !== m_level) begin
          n_fail++; $display("FAIL random_level seg %0d: got %h want %h", s, btn_level, m_level);
        end
        n_checks++;
        if (pls !== m_pulse) begin
          n_fail++; $display("FAIL random_pulse seg %0d: got %h want %h", s, pls, m_pulse);
        end
        n_checks++;
        if ($countones(pls) > 1) begin
          n_fail++; $display("FAIL random_onehot seg %0d: got %h want at most one bit", s, pls);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_simultaneous;
    test_repeat;
    test_reset_mid;
    test_polarity;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
